// File: rtl/seven_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_pkg;

  typedef enum logic {SCAN_BLANK, SCAN_SHOW} scan_state_t;

  localparam logic [7:0] CA_OFF = 8'hFF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seven_decimal.sv
// BCD to seven-segment decoder, active-high: bit 7 = point, bits 6:0 = g..a.
// Codes 10..15 leave the segments dark; the point is always passed through.
module seven_decimal (
  input  logic [3:0] digit,
  input  logic       point,
  output logic [7:0] seg
);

  logic [6:0] segs;

  always_comb begin
    segs = 7'h00;
    case (digit)
      4'd0:    segs = 7'h3F;
      4'd1:    segs = 7'h06;
      4'd2:    segs = 7'h5B;
      4'd3:    segs = 7'h4F;
      4'd4:    segs = 7'h66;
      4'd5:    segs = 7'h6D;
      4'd6:    segs = 7'h7D;
      4'd7:    segs = 7'h07;
      4'd8:    segs = 7'h7F;
      4'd9:    segs = 7'h6F;
      default: segs = 7'h00;
    endcase
  end

  assign seg = {point, segs};

endmodule

// File: rtl/seven_scan.sv
// Time-multiplexed seven-segment scan controller with a double-buffered frame.
// Define SEVEN_SCAN_ZERO_BLANK_EN to suppress leading zeros.
module seven_scan
  import seven_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [4*DIGITS-1:0]   upd_digits,
  input  logic [DIGITS-1:0]     upd_points,
  input  logic [DIGITS-1:0]     upd_mask,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            ca,
  output logic                  frame_start
);

  localparam int CNT_W = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  scan_state_t         state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                restart_reg, restart_next;
  logic                boundary, xfer, accept;

  logic [4*DIGITS-1:0] pend_digits_reg, disp_digits_reg, disp_digits_next;
  logic [DIGITS-1:0]   pend_points_reg, disp_points_reg, disp_points_next;
  logic [DIGITS-1:0]   pend_mask_reg, disp_mask_reg, disp_mask_next;
  logic                pend_full_reg, pend_full_next;

  logic [DIGITS-1:0]   an_reg, an_next;
  logic [7:0]          ca_reg, ca_next;
  logic                fs_reg, fs_next;
  logic                ready_reg;
  logic [7:0]          seg_raw, seg_shown;
  logic                dark;

  // restart_reg marks "next enabled cycle begins a fresh frame" (after reset or en low)
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    restart_next = 1'b0;
    boundary     = 1'b0;
    fs_next      = 1'b0;
    if (!en) begin
      state_next   = SCAN_BLANK;
      idx_next     = '0;
      cnt_next     = BLANK_LD;
      restart_next = 1'b1;
      boundary     = 1'b1;
    end else if (restart_reg) begin
      idx_next = '0;
      fs_next  = 1'b1;
      boundary = 1'b1;
      if (BLANK_CYCLES > 0) begin
        state_next = SCAN_BLANK;
        cnt_next   = BLANK_LD;
      end else begin
        state_next = SCAN_SHOW;
        cnt_next   = DWELL_LD;
      end
    end else if (cnt_reg > CNT_W'(1)) begin
      cnt_next = cnt_reg - 1'b1;
    end else if (state_reg == SCAN_BLANK) begin
      state_next = SCAN_SHOW;
      cnt_next   = DWELL_LD;
    end else begin
      if (idx_reg == IDX_LAST) begin
        idx_next = '0;
        boundary = 1'b1;
        fs_next  = 1'b1;
      end else begin
        idx_next = idx_reg + 1'b1;
      end
      if (BLANK_CYCLES > 0) begin
        state_next = SCAN_BLANK;
        cnt_next   = BLANK_LD;
      end else begin
        state_next = SCAN_SHOW;
        cnt_next   = DWELL_LD;
      end
    end
  end

  // Pending frame only moves to the display at a boundary, so no frame tears.
  assign accept           = upd_valid & ready_reg;
  assign xfer             = boundary & pend_full_reg;
  assign disp_digits_next = xfer ? pend_digits_reg : disp_digits_reg;
  assign disp_points_next = xfer ? pend_points_reg : disp_points_reg;
  assign disp_mask_next   = xfer ? pend_mask_reg   : disp_mask_reg;
  assign pend_full_next   = accept ? 1'b1 : (xfer ? 1'b0 : pend_full_reg);

`ifdef SEVEN_SCAN_ZERO_BLANK_EN
  logic [DIGITS-1:0] supp_reg, supp_calc, supp_next;
  logic              seen;

  always_comb begin
    supp_calc = '0;
    seen      = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      supp_calc[i] = !seen && (disp_digits_next[4*i +: 4] == 4'd0);
      if (disp_mask_next[i] && (disp_digits_next[4*i +: 4] != 4'd0))
        seen = 1'b1;
    end
  end

  assign supp_next = boundary ? supp_calc : supp_reg;
  assign dark      = supp_next[idx_next];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) supp_reg <= '0;
    else     supp_reg <= supp_next;
  end
`else
  assign dark = 1'b0;
`endif

  seven_decimal u_dec (
    .digit (disp_digits_next[idx_next*4 +: 4]),
    .point (disp_points_next[idx_next]),
    .seg   (seg_raw)
  );

  assign seg_shown = {seg_raw[7], dark ? 7'h00 : seg_raw[6:0]};

  // Outputs are computed from the next state so they line up with the registered state.
  always_comb begin
    an_next = '1;
    ca_next = CA_OFF;
    if (en && state_next == SCAN_SHOW) begin
      if (disp_mask_next[idx_next])
        an_next = ~(DIGITS'(1) << idx_next);
      ca_next = ~seg_shown;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= SCAN_BLANK;
      idx_reg         <= '0;
      cnt_reg         <= '0;
      restart_reg     <= 1'b1;
      pend_digits_reg <= '0;
      pend_points_reg <= '0;
      pend_mask_reg   <= '0;
      pend_full_reg   <= 1'b0;
      disp_digits_reg <= '0;
      disp_points_reg <= '0;
      disp_mask_reg   <= '0;
      ready_reg       <= 1'b1;
      an_reg          <= '1;
      ca_reg          <= CA_OFF;
      fs_reg          <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      cnt_reg         <= cnt_next;
      restart_reg     <= restart_next;
      if (accept) begin
        pend_digits_reg <= upd_digits;
        pend_points_reg <= upd_points;
        pend_mask_reg   <= upd_mask;
      end
      pend_full_reg   <= pend_full_next;
      disp_digits_reg <= disp_digits_next;
      disp_points_reg <= disp_points_next;
      disp_mask_reg   <= disp_mask_next;
      ready_reg       <= ~pend_full_next;
      an_reg          <= an_next;
      ca_reg          <= ca_next;
      fs_reg          <= fs_next;
    end
  end

  assign an          = an_reg;
  assign ca          = ca_reg;
  assign frame_start = fs_reg;
  assign upd_ready   = ready_reg;

endmodule

// File: tb/tb_seven_scan.sv
// Directed self-checking bench for seven_scan (DIGITS=4, DWELL=4, BLANK=1).
// Leading-zero expectations follow SEVEN_SCAN_ZERO_BLANK_EN.
module tb_seven_scan;

  logic        clk;
  logic        rst;
  logic        en;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_digits;
  logic [3:0]  upd_points;
  logic [3:0]  upd_mask;
  logic [3:0]  an;
  logic [7:0]  ca;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  seven_scan #(
    .DIGITS       (4),
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_digits  (upd_digits),
    .upd_points  (upd_points),
    .upd_mask    (upd_mask),
    .an          (an),
    .ca          (ca),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer a frame and hold it until accepted; returns on the negedge after acceptance.
  task automatic offer(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m);
    int n;
    upd_digits = d;
    upd_points = p;
    upd_mask   = m;
    upd_valid  = 1'b1;
    n = 0;
    while (!upd_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("offer_timeout", {31'd0, upd_ready}, 32'd1);
    @(negedge clk);
    upd_valid = 1'b0;
    $display("offer digits=%h points=%b mask=%b accepted after %0d waits", d, p, m, n);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 60);
    check("fs_timeout", {31'd0, frame_start}, 32'd1);
  endtask

  // Called on the frame_start cycle; checks all 20 cycles of one frame.
  task automatic scan_frame(input string tag, input logic [15:0] exp_an, input logic [31:0] exp_ca);
    int slot, ph;
    logic [3:0] ea;
    logic [7:0] ec;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      slot = k / 5;
      ph   = k % 5;
      ea   = (ph == 0) ? 4'hF  : exp_an[slot*4 +: 4];
      ec   = (ph == 0) ? 8'hFF : exp_ca[slot*8 +: 8];
      check($sformatf("%s_k%0d", tag, k), {20'd0, an, ca}, {20'd0, ea, ec});
      if (k < 2) check($sformatf("%s_fs%0d", tag, k), {31'd0, frame_start}, {31'd0, k == 0});
    end
    $display("frame %s scanned", tag);
  endtask

  logic [7:0] last_ca;
  int         n;

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    upd_valid  = 1'b0;
    upd_digits = '0;
    upd_points = '0;
    upd_mask   = '0;
    repeat (3) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_ca", {24'd0, ca}, 32'hFF);
    check("rst_fs", {31'd0, frame_start}, 32'd0);
    check("rst_ready", {31'd0, upd_ready}, 32'd1);

    // Load a frame while disabled; it reaches the display before scanning starts.
    rst = 1'b0;
    offer(16'h4321, 4'b0000, 4'hF);
    @(negedge clk);
    check("ready_after_load", {31'd0, upd_ready}, 32'd1);
    en = 1'b1;
    @(negedge clk);
    scan_frame("f4321", 16'h7BDE, 32'h99B0A4F9);
    @(negedge clk);
    check("period_fs", {31'd0, frame_start}, 32'd1);

    // Mid-frame update, then a second one held while pending is full.
    repeat (7) @(negedge clk);
    offer(16'h9999, 4'b0000, 4'hF);
    check("ready_low_pending", {31'd0, upd_ready}, 32'd0);
    upd_digits = 16'h765A;
    upd_points = 4'b0001;
    upd_mask   = 4'b1011;
    upd_valid  = 1'b1;
    n = 0;
    last_ca = 8'h00;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (frame_start) break;
      check($sformatf("held_ready_%0d", n), {31'd0, upd_ready}, 32'd0);
      last_ca = ca;
    end
    check("boundary_fs", {31'd0, frame_start}, 32'd1);
    check("old_frame_tail_ca", {24'd0, last_ca}, 32'h99);
    check("ready_at_boundary", {31'd0, upd_ready}, 32'd1);
    fork
      begin
        @(negedge clk);
        upd_valid = 1'b0;
      end
    join_none
    scan_frame("f9999", 16'h7BDE, 32'h90909090);
    check("second_pending", {31'd0, upd_ready}, 32'd0);
    wait_fs();
    scan_frame("f765A", 16'h7FDE, 32'hF882927F);

    // Drop en during digit 2, then restart.
    wait_fs();
    repeat (12) @(negedge clk);
    check("digit2_ca", {24'd0, ca}, 32'h82);
    en = 1'b0;
    @(negedge clk);
    check("en_off_an", {28'd0, an}, 32'hF);
    check("en_off_ca", {24'd0, ca}, 32'hFF);
    check("en_off_fs", {31'd0, frame_start}, 32'd0);
    repeat (2) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    scan_frame("restart", 16'h7FDE, 32'hF882927F);

    // Asynchronous reset mid-SHOW with a frame pending.
    repeat (3) @(negedge clk);
    offer(16'h1111, 4'b0000, 4'hF);
    check("pend_before_rst", {31'd0, upd_ready}, 32'd0);
    check("show_before_rst", {28'd0, an}, 32'hE);
    #2 rst = 1'b1;
    #1;
    check("arst_an", {28'd0, an}, 32'hF);
    check("arst_ca", {24'd0, ca}, 32'hFF);
    check("arst_ready", {31'd0, upd_ready}, 32'd1);
    check("arst_fs", {31'd0, frame_start}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    scan_frame("cleared", 16'hFFFF, 32'hC0C0C0C0);

    // Leading-zero frame.
    offer(16'h0050, 4'b0000, 4'hF);
    wait_fs();
`ifdef SEVEN_SCAN_ZERO_BLANK_EN
    scan_frame("f0050", 16'h7BDE, 32'hFFFF92C0);
`else
    scan_frame("f0050", 16'h7BDE, 32'hC0C092C0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_scan.md
Name: seven_scan

Overview:
- Time-multiplexed scan controller for a bank of common-anode seven-segment digits sharing one cathode bus.
- Holds a double-buffered BCD frame (digits plus decimal points) supplied by upstream logic over a valid/ready handshake.
- Cycles one anode at a time with a blanking gap between digits to prevent ghosting, and decodes each digit through the existing seven_decimal decoder.
- Sits between status/counter logic and the board's AN/CA pins.

Parameters:
- DIGITS, 8, number of digits scanned; legal range 1..16.
- DWELL_CYCLES, 100000, clock cycles each digit's anode is driven; must be >= 1.
- BLANK_CYCLES, 2000, clock cycles with all anodes off before each digit; 0 disables blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  scan enable; 0 forces the display dark.
- upd_valid  in  1  new frame offered.
- upd_ready  out  1  pending buffer empty; frame accepted when upd_valid & upd_ready.
- upd_digits  in  4*DIGITS  BCD per digit; digit i is bits [4i+3:4i].
- upd_points  in  DIGITS  decimal point per digit, 1 = lit.
- upd_mask  in  DIGITS  digit enable, 0 = anode never driven for that digit.
- an  out  DIGITS  anodes, active-low, one-hot-low or all ones.
- ca  out  8  cathodes, active-low; bit 7 = point, bits 6:0 = segments g..a.
- frame_start  out  1  single-cycle pulse on the first cycle of each frame.

Behaviour:
- Reset values:
  - an = all ones; ca = 8'hFF; frame_start = 0; upd_ready = 1.
  - Pending and display buffers cleared; digit index = 0; state = SCAN_BLANK; counter = 0.
- All outputs are registered; an/ca reflect the current state in the same cycle the state is held.
- State machine:
  - SCAN_BLANK: an all ones, ca = 8'hFF, for BLANK_CYCLES cycles, then go to SCAN_SHOW. If BLANK_CYCLES = 0 the state is skipped entirely.
  - SCAN_SHOW: lasts exactly DWELL_CYCLES cycles.
    - an[idx] = 0 if the display mask bit is 1, otherwise all ones.
    - ca = ~seven_decimal(digit[idx], point[idx]).
    - Then idx increments and the FSM returns to SCAN_BLANK (or SCAN_SHOW when BLANK_CYCLES = 0).
- Wrap and frame boundary:
  - idx wraps from DIGITS-1 to 0; this wrap is the frame boundary.
  - Frame period = DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Counter width = $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1); it counts down to 1, then reloads.
- Handshake and buffering:
  - upd_ready = ~pending_full (registered).
  - On acceptance, digits/points/mask are captured into the pending buffer and pending_full is set.
  - At the frame boundary, a full pending buffer is copied into the display buffer and pending_full clears; upd_ready rises the following cycle.
  - A frame is never displayed partially (no tearing).
- frame_start:
  - Asserts on the first cycle after the frame boundary, i.e. the first cycle with idx = 0.
  - Also asserts on the first cycle after reset release and on the first enabled cycle after en rises.
- en = 0:
  - Next cycle: an all ones, ca = 8'hFF, idx = 0, state = SCAN_BLANK, counter reloaded.
  - The handshake still operates, and a full pending buffer transfers to the display buffer every cycle.
  - On en rising, scanning restarts at digit 0 with a frame_start pulse.
- Digit codes 10..15: segments dark; the point still follows upd_points.
- Reset mid-frame: immediate return to reset values; any pending frame is discarded.

Optional Feature:
- Macro SEVEN_SCAN_ZERO_BLANK_EN.
- When defined, leading zeros are suppressed:
  - A digit whose code is 0 has its segments forced dark when every higher-index digit is either 0 or masked.
  - Digit 0 is never suppressed.
  - Points are unaffected.
  - The suppression vector is computed once at the frame boundary, not per digit.
- When undefined, all digits are shown as decoded and no suppression logic is synthesised.

Decomposition:
- Package seven_pkg holds:
  - typedef enum logic {SCAN_BLANK, SCAN_SHOW} scan_state_t;
  - localparam logic [7:0] CA_OFF = 8'hFF;
  - a function returning the max of two ints, used for the counter width.
- One sub-module: seven_decimal, instantiated once on the muxed digit, with its output inverted for ca.

Test Plan:
- Bench configuration: DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=1.
- Reset then frame 16'h4321, points 4'b0000, mask 4'hF → an sequence per 5-cycle slot is 1111,1110×4, then 1111,1101×4, etc.; ca during digit 0 = ~8'h06, during digit 3 = ~8'h66; frame period 20 cycles.
- Update offered mid-frame with 16'h9999 → accepted with upd_ready then 0; old digits finish the frame; new value first appears after the frame_start pulse; upd_ready returns to 1 one cycle after the boundary.
- Second update held valid while pending is full → not accepted until the boundary; no frame loss, no tearing.
- Mask 4'b1011, digit code 4'hA on digit 0 with point 1 → an[2] never low; digit 0 ca = 8'h7F.
- en dropped during digit 2 → next cycle an = 4'hF, ca = 8'hFF; on en rising, frame_start pulses and the scan restarts at digit 0. Also assert rst mid-SHOW → outputs return to reset values asynchronously.
- With SEVEN_SCAN_ZERO_BLANK_EN defined, frame 16'h0050 → digits 3 and 2 dark, digits 1 and 0 show 5 and 0; with the macro undefined, all four digits are lit.
